// File: rtl/reg_file.sv
// Architectural integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-to-read forwarding.

module reg_file_mux #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0][XLEN-1:0] data,
  input  logic [AW-1:0]              sel,
  output logic [XLEN-1:0]            out
);

  logic [XLEN-1:0] node [NREGS];

  // Binary mux tree: each stage halves the candidates using one address bit, LSB first.
  always_comb begin
    for (int i = 0; i < NREGS; i++) node[i] = data[i];
    for (int s = 0; s < AW; s++) begin
      for (int p = 0; p < (NREGS >> (s + 1)); p++) begin
        node[p] = sel[s] ? node[2*p+1] : node[2*p];
      end
    end
    out = node[0];
  end

endmodule

module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [NREGS-1:1][XLEN-1:0] regs;
  logic [NREGS-1:1]           wsel;
  logic [NREGS-1:0][XLEN-1:0] leaves;
  logic [XLEN-1:0]            mux1;
  logic [XLEN-1:0]            mux2;
  logic                       fwd1;
  logic                       fwd2;

  // Write decoder; x0 has no storage and therefore no select line.
  always_comb begin
    wsel = '0;
    for (int i = 1; i < NREGS; i++) begin
      wsel[i] = we && (wa == AW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wsel[i]) regs[i] <= wd;
      end
    end
  end

  assign leaves = {regs, {XLEN{1'b0}}};

  reg_file_mux #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_mux1 (
    .data(leaves), .sel(ra1), .out(mux1)
  );

  reg_file_mux #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_mux2 (
    .data(leaves), .sel(ra2), .out(mux2)
  );

  // Forwarding is suppressed during reset so reads stay zero while it is held.
  assign fwd1 = (BYPASS != 0) && !reset && we && (wa != '0) && (wa == ra1);
  assign fwd2 = (BYPASS != 0) && !reset && we && (wa != '0) && (wa == ra2);

  assign rd1 = reset ? '0 : fwd1 ? wd : (ra1 == '0) ? '0 : mux1;
  assign rd2 = reset ? '0 : fwd2 ? wd : (ra2 == '0) ? '0 : mux2;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; runs a non-forwarding and a
// forwarding instance side by side on shared inputs.

module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1_nb, rd2_nb;
  logic [31:0] rd1_bp, rd2_bp;

  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  reg_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb)
  );

  reg_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) u_dut_bp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_bp), .rd2(rd2_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    wa = addr;
    wd = data;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic sweep_model(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check_output($sformatf("%s_nb_rd1_x%0d", tag, i), rd1_nb, model[i]);
      check_output($sformatf("%s_nb_rd2_x%0d", tag, 31 - i), rd2_nb, model[31 - i]);
      check_output($sformatf("%s_bp_rd1_x%0d", tag, i), rd1_bp, model[i]);
      check_output($sformatf("%s_bp_rd2_x%0d", tag, 31 - i), rd2_bp, model[31 - i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    wa    = '0;
    wd    = '0;
    ra1   = '0;
    ra2   = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset held for two cycles, then every address reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    sweep_model("reset");
    reset = 1'b0;

    // Basic write and read, with ALU add/sub on the operands.
    write_reg(5'd5, 32'h0000000A);
    write_reg(5'd6, 32'h00000003);
    @(negedge clk);
    ra1 = 5'd5;
    ra2 = 5'd6;
    #1;
    check_output("basic_rd1", rd1_nb, 32'h0000000A);
    check_output("basic_rd2", rd2_nb, 32'h00000003);
    check_output("alu_add", rd1_nb + rd2_nb, 32'h0000000D);
    check_output("alu_sub", rd1_nb - rd2_nb, 32'h00000007);

    // Same address on both ports.
    ra2 = 5'd5;
    #1;
    check_output("same_addr_rd1", rd1_nb, 32'h0000000A);
    check_output("same_addr_rd2", rd2_nb, 32'h0000000A);

    // Write to x0 is discarded; nothing else moves.
    write_reg(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    check_output("x0_rd1", rd1_nb, 32'h0);
    check_output("x0_rd2", rd2_nb, 32'h0);
    sweep_model("after_x0");

    // Write disabled: x7 stays zero.
    @(negedge clk);
    we  = 1'b0;
    wa  = 5'd7;
    wd  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    ra1 = 5'd7;
    ra2 = 5'd7;
    #1;
    check_output("we0_x7_nb", rd1_nb, 32'h0);
    check_output("we0_x7_bp", rd1_bp, 32'h0);

    // Same-cycle write and read of x7.
    we = 1'b1;
    #1;
    check_output("pre_edge_nb_rd1", rd1_nb, 32'h0);
    check_output("pre_edge_nb_rd2", rd2_nb, 32'h0);
    check_output("pre_edge_bp_rd1", rd1_bp, 32'h12345678);
    check_output("pre_edge_bp_rd2", rd2_bp, 32'h12345678);
    @(posedge clk);
    #1;
    we = 1'b0;
    model[7] = 32'h12345678;
    check_output("post_edge_nb_rd1", rd1_nb, 32'h12345678);
    check_output("post_edge_bp_rd1", rd1_bp, 32'h12345678);

    // Forwarding never applies to x0.
    @(negedge clk);
    we  = 1'b1;
    wa  = 5'd0;
    wd  = 32'h55555555;
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    check_output("bp_x0_rd1", rd1_bp, 32'h0);
    check_output("bp_x0_rd2", rd2_bp, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;

    // Asynchronous reset mid-operation.
    write_reg(5'd9, 32'hDEADBEEF);
    @(negedge clk);
    ra1 = 5'd9;
    ra2 = 5'd5;
    #1;
    check_output("x9_before_reset", rd1_nb, 32'hDEADBEEF);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset_x9", rd1_nb, 32'h0);
    check_output("async_reset_x5", rd2_nb, 32'h0);
    we = 1'b1;
    wa = 5'd9;
    wd = 32'h00000001;
    #1;
    check_output("reset_bp_suppressed", rd1_bp, 32'h0);
    @(posedge clk);
    #1;
    check_output("reset_write_ignored", rd1_nb, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset released between edges with a write pending: takes effect on the next edge.
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b1;
    wa    = 5'd3;
    wd    = 32'h00000033;
    ra1   = 5'd9;
    ra2   = 5'd3;
    #1;
    check_output("x9_after_reset", rd1_nb, 32'h0);
    check_output("x3_before_first_edge", rd2_nb, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    model[3] = 32'h00000033;
    check_output("first_write_after_reset", rd2_nb, 32'h00000033);

    // Full sweep: distinct value per register, all pairs read back.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    @(negedge clk);
    sweep_model("full");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
